// File: rtl/demux_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshake and broadcast.
// Each channel owns a one-word slot; invalid selects are dropped and counted.

module demux_hs_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load wins over drain so a slot emptied this cycle can be refilled at the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

module demux_hs #(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err_sel,
  output logic [7:0]             drop_cnt
);
  localparam int NP = 1 << SEL_W;
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0] free, load;
  logic [NP-1:0]    free_pad;
  logic             sel_ok, accept, drop;
  logic             err_sel_q, err_sel_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // free_pad covers every encodable select so the lookup never indexes past N_OUT.
  always_comb begin
    free     = ~out_valid | out_ready;
    free_pad = NP'(free);
    sel_ok   = {1'b0, in_sel} < N_LIM;
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = free_pad[in_sel];
    else             in_ready = 1'b1;
    accept     = in_valid & in_ready;
    drop       = accept & ~in_bcast & ~sel_ok;
    err_sel_d  = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_sel_q  <= err_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_ch
    assign load[i] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(i))));
    demux_hs_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .drain (out_ready[i]),
      .din   (in_data),
      .valid (out_valid[i]),
      .data  (out_data[i*WIDTH +: WIDTH])
    );
  end

  assign err_sel  = err_sel_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: doc/demux_hs.md
# demux_hs

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking, the next generation of the team's combinational 1-to-4 demux. One input stream is routed by a select field to one of N_OUT output channels, or broadcast to all of them. Each channel holds one registered data slot, so downstream backpressure stalls only the affected traffic. Sits between a single producer and N independent consumers.

## Interface
- WIDTH, 8: data width in bits (≥1).
- N_OUT, 4: number of output channels (2..16).
- SEL_W (localparam): $clog2(N_OUT); not overridable.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  1 = broadcast to all channels; in_sel is ignored.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- out_data  out  N_OUT*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- out_valid  out  N_OUT  channel i slot full.
- out_ready  in  N_OUT  consumer i takes its word.
- err_sel  out  1  one-cycle pulse: a word with in_sel ≥ N_OUT was dropped.
- drop_cnt  out  8  count of dropped words, saturating.

## Operation
- Transfers: input when in_valid & in_ready at a rising edge; channel i when out_valid[i] & out_ready[i].
- free[i] = ~out_valid[i] | out_ready[i]. A slot draining in a cycle may be refilled in the same cycle.
- in_ready, combinational:
  - unicast, in_sel < N_OUT: free[in_sel];
  - unicast, in_sel ≥ N_OUT: 1 (the word is dropped);
  - broadcast: AND of all free[i].
- On an accepted unicast word: slot in_sel loads in_data and out_valid[in_sel] is set. No other slot changes.
- On an accepted broadcast word: every slot loads in_data and every out_valid bit is set, all at the same edge. A broadcast never partially completes.
- On an accepted invalid-select word: no slot changes. err_sel = 1 for the following cycle. drop_cnt increments and holds at 255.
- Draining: out_valid[i] clears on a channel-i transfer, unless the same edge refills slot i.
- out_data[i] holds its value while out_valid[i] is 0. It is not cleared on drain.
- in_ready is don't-care while in_valid = 0. Output requirements: out_valid never drops without a transfer, and out_data[i] is stable while out_valid[i] & ~out_ready[i].
- Per-slot state: EMPTY ↔ FULL.
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain without reload.
  - FULL→FULL on drain with reload, or on no transfer.

## Timing
- Reset (async assert, sync release): out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0. in_ready then follows the combinational rules, so it is 1 for in_valid with a valid sel.
- Reset asserted mid-operation: all held words are discarded immediately. No partial broadcast survives.
- Latency: word accepted at edge k → out_valid high and out_data valid after edge k (one cycle).
- Throughput: one word per cycle per channel while out_ready is held high. An aggregate of one input word per cycle.
- Combinational paths: out_ready → in_ready, in_sel/in_bcast → in_ready. No path from input to outputs other than in_ready.
- err_sel asserts the cycle after the dropping edge. Back-to-back drops keep err_sel high on consecutive cycles.

## Test plan
- Reset/basic: reset, then drive sel = 0..3 with data 8'hA0..8'hA3 and all out_ready = 1.
  - Each out_valid[i] pulses for one cycle, one cycle after acceptance, with out_data[i] = A0+i.
  - Other channels stay 0.
- Backpressure: out_ready[2] = 0; send 8'h11 then 8'h22 to ch 2.
  - First is accepted; in_ready = 0 for the second.
  - out_data[2] holds 8'h11.
  - Raise out_ready[2]: 8'h22 is accepted the same edge 8'h11 drains. out_valid[2] stays 1 and shows 8'h22 next cycle.
- Broadcast: ch 1 full and stalled; send 8'h5A with in_bcast = 1.
  - in_ready = 0; no slot changes.
  - Release ch 1: all four slots show 8'h5A after the same edge.
- Invalid select, with N_OUT = 3: send sel = 3 three times.
  - in_ready = 1; no out_valid changes.
  - err_sel high for 3 cycles; drop_cnt = 3.
  - 300 drops → drop_cnt = 255.
- Async reset mid-stream: assert rst_n = 0 between edges while slots hold data.
  - out_valid = 0 and drop_cnt = 0 immediately.
  - After release, the first new word routes correctly.
- Random soak, WIDTH = 16, N_OUT = 8: random valid/ready/sel/bcast.
  - Scoreboard per channel: order preserved, no loss or duplication.
  - Drops counted exactly.
